// File: rtl/nco_acc_seq.sv
// Time-shared phase-accumulator sequencer: steps NCH 48-bit NCO phases through one
// external registered 24-bit adder, low word then high word with carry.
module nco_acc_seq #(
    parameter int NCH = 4,
    parameter int CW  = 2
) (
    input  logic          CLK,
    input  logic          SCLR,
    input  logic          START,
    input  logic          FWE,
    input  logic [CW-1:0] FADDR,
    input  logic [47:0]   FDATA,
    output logic [23:0]   ADD_A,
    output logic [23:0]   ADD_B,
    output logic          ADD_CI,
    output logic          ADD_CE,
    output logic          ADD_SCLR,
    input  logic [23:0]   ADD_Q,
    input  logic          ADD_CO,
    output logic [23:0]   PHASE_OUT,
    output logic [CW-1:0] PCH,
    output logic          PVLD,
    output logic          DONE,
    output logic          BUSY,
    output logic          OVR
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_LAST
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] ch_q, ch_d;

    logic [23:0]   phase_lo_q [NCH];
    logic [23:0]   phase_hi_q [NCH];
    logic [47:0]   shadow_q   [NCH];
    logic [47:0]   freq_q     [NCH];

    logic [23:0]   phase_out_q;
    logic [CW-1:0] pch_q;
    logic          pvld_q;
    logic          done_q;
    logic          ovr_q;

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        ADD_A   = '0;
        ADD_B   = '0;
        ADD_CI  = 1'b0;
        ADD_CE  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_LO;
                    ch_d    = '0;
                end
            end
            S_LO: begin
                ADD_A   = phase_lo_q[ch_q];
                ADD_B   = freq_q[ch_q][23:0];
                ADD_CE  = 1'b1;
                state_d = S_HI;
            end
            S_HI: begin
                // ADD_CO here is the registered carry of the low word issued last cycle
                ADD_A  = phase_hi_q[ch_q];
                ADD_B  = freq_q[ch_q][47:24];
                ADD_CI = ADD_CO;
                ADD_CE = 1'b1;
                if (ch_q == CW'(NCH - 1)) begin
                    state_d = S_LAST;
                end else begin
                    state_d = S_LO;
                    ch_d    = ch_q + CW'(1);
                end
            end
            S_LAST: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (SCLR) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            phase_out_q <= '0;
            pch_q       <= '0;
            pvld_q      <= 1'b0;
            done_q      <= 1'b0;
            ovr_q       <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                phase_lo_q[i] <= '0;
                phase_hi_q[i] <= '0;
                shadow_q[i]   <= '0;
                freq_q[i]     <= '0;
            end
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            pvld_q  <= 1'b0;
            done_q  <= 1'b0;

            if (FWE) begin
                shadow_q[FADDR] <= FDATA;
            end

            // Non-blocking copy reads the pre-write shadow, so a same-cycle FWE lands next round
            if (START && state_q == S_IDLE) begin
                for (int unsigned i = 0; i < NCH; i++) begin
                    freq_q[i] <= shadow_q[i];
                end
            end
            if (START && state_q != S_IDLE) begin
                ovr_q <= 1'b1;
            end

            case (state_q)
                S_LO: begin
                    if (ch_q != '0) begin
                        phase_hi_q[ch_q - CW'(1)] <= ADD_Q;
                        phase_out_q               <= ADD_Q;
                        pch_q                     <= ch_q - CW'(1);
                        pvld_q                    <= 1'b1;
                    end
                end
                S_HI: begin
                    phase_lo_q[ch_q] <= ADD_Q;
                end
                S_LAST: begin
                    phase_hi_q[NCH-1] <= ADD_Q;
                    phase_out_q       <= ADD_Q;
                    pch_q             <= CW'(NCH - 1);
                    pvld_q            <= 1'b1;
                    done_q            <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign ADD_SCLR  = SCLR;
    assign PHASE_OUT = phase_out_q;
    assign PCH       = pch_q;
    assign PVLD      = pvld_q;
    assign DONE      = done_q;
    assign BUSY      = (state_q != S_IDLE);
    assign OVR       = ovr_q;

endmodule

// File: tb/tb_nco_acc_seq.sv
// Scoreboard bench for nco_acc_seq with a behavioural registered 24-bit adder;
// directed rounds with hand-computed phase results.
module tb_nco_acc_seq;

    localparam int NCH = 4;
    localparam int CW  = 2;

    logic          CLK;
    logic          SCLR;
    logic          START;
    logic          FWE;
    logic [CW-1:0] FADDR;
    logic [47:0]   FDATA;
    logic [23:0]   ADD_A;
    logic [23:0]   ADD_B;
    logic          ADD_CI;
    logic          ADD_CE;
    logic          ADD_SCLR;
    logic [23:0]   ADD_Q;
    logic          ADD_CO;
    logic [23:0]   PHASE_OUT;
    logic [CW-1:0] PCH;
    logic          PVLD;
    logic          DONE;
    logic          BUSY;
    logic          OVR;

    nco_acc_seq #(.NCH(NCH), .CW(CW)) dut (
        .CLK      (CLK),
        .SCLR     (SCLR),
        .START    (START),
        .FWE      (FWE),
        .FADDR    (FADDR),
        .FDATA    (FDATA),
        .ADD_A    (ADD_A),
        .ADD_B    (ADD_B),
        .ADD_CI   (ADD_CI),
        .ADD_CE   (ADD_CE),
        .ADD_SCLR (ADD_SCLR),
        .ADD_Q    (ADD_Q),
        .ADD_CO   (ADD_CO),
        .PHASE_OUT(PHASE_OUT),
        .PCH      (PCH),
        .PVLD     (PVLD),
        .DONE     (DONE),
        .BUSY     (BUSY),
        .OVR      (OVR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // External adder: one-cycle registered sum and carry
    always @(posedge CLK) begin
        if (ADD_SCLR) begin
            ADD_Q  <= '0;
            ADD_CO <= 1'b0;
        end else if (ADD_CE) begin
            {ADD_CO, ADD_Q} <= {1'b0, ADD_A} + {1'b0, ADD_B} + {24'b0, ADD_CI};
        end
    end

    typedef struct packed {
        logic [CW-1:0] pch;
        logic [23:0]   ph;
        logic          done;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    logic ci_at_ch1_hi;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input int ch, input logic [23:0] ph);
        exp_t e;
        e.pch  = CW'(ch);
        e.ph   = ph;
        e.done = (ch == NCH - 1);
        sb_q.push_back(e);
    endtask

    task automatic write_freq(input int ch, input logic [47:0] data);
        @(posedge CLK); #1;
        FWE   = 1'b1;
        FADDR = CW'(ch);
        FDATA = data;
        @(posedge CLK); #1;
        FWE   = 1'b0;
    endtask

    // Cycle 0 is the cycle START is presented; outputs checked at the start of each cycle
    task automatic run_round(input int ovr_cyc, input int sclr_cyc, input int fwe_ch,
                             input logic [47:0] fwe_data, input int ncyc);
        bit aborted;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge CLK); #1;
            aborted = (sclr_cyc >= 0) && (c > sclr_cyc);
            chk($sformatf("busy_c%0d", c), 48'(BUSY),
                48'(!aborted && c >= 1 && c <= 2*NCH + 1));
            chk($sformatf("done_c%0d", c), 48'(DONE), 48'(!aborted && c == 2*NCH + 2));
            chk($sformatf("pvld_c%0d", c), 48'(PVLD),
                48'(!aborted && c >= 4 && c <= 2*NCH + 2 && (c % 2) == 0));
            chk($sformatf("add_ce_c%0d", c), 48'(ADD_CE), 48'(!aborted && c >= 1 && c <= 2*NCH));
            if (c == 4) ci_at_ch1_hi = ADD_CI;
            if (sclr_cyc >= 0 && c == sclr_cyc + 1) begin
                chk("abort_phase_out", 48'(PHASE_OUT), 48'h0);
                chk("abort_ovr", 48'(OVR), 48'h0);
            end
            START = (c == 0) || (c == ovr_cyc);
            SCLR  = (c == sclr_cyc);
            FWE   = (c == 0) && (fwe_ch >= 0);
            FADDR = CW'(fwe_ch);
            FDATA = fwe_data;
        end
        START = 1'b0;
        SCLR  = 1'b0;
        FWE   = 1'b0;
    endtask

    // Monitor: pops and compares whenever the DUT strobes PVLD
    always @(negedge CLK) begin
        exp_t e;
        if (PVLD === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pvld: got PCH=%0d PHASE_OUT=%h, expected no output",
                         PCH, PHASE_OUT);
            end else begin
                e = sb_q.pop_front();
                if (PCH !== e.pch || PHASE_OUT !== e.ph || DONE !== e.done) begin
                    errors++;
                    $display("FAIL phase_out: got PCH=%0d PHASE_OUT=%h DONE=%b, expected PCH=%0d PHASE_OUT=%h DONE=%b",
                             PCH, PHASE_OUT, DONE, e.pch, e.ph, e.done);
                end
            end
        end
    end

    initial begin
        SCLR  = 1'b1;
        START = 1'b0;
        FWE   = 1'b0;
        FADDR = '0;
        FDATA = '0;
        ci_at_ch1_hi = 1'b0;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_add_sclr", 48'(ADD_SCLR), 48'h1);
        chk("rst_add_ce", 48'(ADD_CE), 48'h0);
        chk("rst_busy", 48'(BUSY), 48'h0);
        chk("rst_pvld", 48'(PVLD), 48'h0);
        chk("rst_done", 48'(DONE), 48'h0);
        chk("rst_ovr", 48'(OVR), 48'h0);
        chk("rst_phase_out", 48'(PHASE_OUT), 48'h0);
        chk("rst_pch", 48'(PCH), 48'h0);
        SCLR = 1'b0;
        @(posedge CLK); #1;
        chk("add_sclr_low", 48'(ADD_SCLR), 48'h0);

        // All frequencies zero
        for (int k = 0; k < NCH; k++) push(k, 24'h000000);
        run_round(-1, -1, -1, 48'h0, 14);

        write_freq(0, 48'h000001_000000);
        write_freq(1, 48'h000000_800000);
        write_freq(2, 48'hFFFFFF_FFFFFF);

        push(0, 24'h000001); push(1, 24'h000000); push(2, 24'hFFFFFF); push(3, 24'h000000);
        run_round(-1, -1, -1, 48'h0, 14);
        chk("ci_ch1_hi_r1", 48'(ci_at_ch1_hi), 48'h0);

        // ch1 low word 800000+800000 carries into the high word
        push(0, 24'h000002); push(1, 24'h000001); push(2, 24'hFFFFFF); push(3, 24'h000000);
        run_round(-1, -1, -1, 48'h0, 14);
        chk("ci_ch1_hi_r2", 48'(ci_at_ch1_hi), 48'h1);
        chk("ovr_after_wrap", 48'(OVR), 48'h0);

        // Ignored START in cycle 5; FWE to ch3 alongside the accepted START
        push(0, 24'h000003); push(1, 24'h000001); push(2, 24'hFFFFFF); push(3, 24'h000000);
        run_round(5, -1, 3, 48'h000005_000000, 14);
        chk("ovr_set", 48'(OVR), 48'h1);

        push(0, 24'h000004); push(1, 24'h000002); push(2, 24'hFFFFFF); push(3, 24'h000005);
        run_round(-1, -1, -1, 48'h0, 14);
        chk("ovr_sticky", 48'(OVR), 48'h1);

        // SCLR in cycle 5: only ch0 emerges before the abort
        push(0, 24'h000005);
        run_round(-1, 5, -1, 48'h0, 14);

        // Cleared phases and frequencies; START in the LAST cycle is ignored
        for (int k = 0; k < NCH; k++) push(k, 24'h000000);
        run_round(2*NCH + 1, -1, -1, 48'h0, 14);
        chk("ovr_last_cycle_start", 48'(OVR), 48'h1);

        repeat (2) @(posedge CLK);
        #1;
        chk("scoreboard_drained", 48'(sb_q.size()), 48'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
